// File: rtl/fmul_seq.sv
// Iterative binary32 multiplier: radix-4 shift-add significand product over 12 cycles,
// then one normalise/round cycle. Denormal inputs flush to zero; results never go subnormal.
`timescale 1ns/1ps
module fmul_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] rslt_o,
  output logic [4:0]  flag_o
);

  localparam int unsigned ITER = 12;
  localparam int unsigned BIAS = 127;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] acc_q, acc_d;
  logic        busy_q, busy_d, valid_q, valid_d;
  logic [31:0] rslt_q, rslt_d;
  logic [4:0]  flag_q, flag_d;

  // Partial product for the current radix-4 digit of the multiplier
  logic [47:0] pp;
  always_comb begin
    unique case (mplier_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = mcand_q;
      2'd2:    pp = mcand_q << 1;
      default: pp = mcand_q + (mcand_q << 1);
    endcase
  end

  // Operand classification on the latched operands
  logic [7:0]  ex, ey;
  logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, sgn, snan;
  assign ex     = x_q[30:23];
  assign ey     = y_q[30:23];
  assign x_nan  = (ex == 8'hFF) && (x_q[22:0] != '0);
  assign y_nan  = (ey == 8'hFF) && (y_q[22:0] != '0);
  assign x_inf  = (ex == 8'hFF) && (x_q[22:0] == '0);
  assign y_inf  = (ey == 8'hFF) && (y_q[22:0] == '0);
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);
  assign sgn    = x_q[31] ^ y_q[31];
  assign snan   = (x_nan && !x_q[22]) || (y_nan && !y_q[22]);

  logic [22:0] mant;
  logic        g, s, inc, carry;
  logic [23:0] mant_r;
  logic [9:0]  e_pre, e_fin;
  logic [31:0] res;
  logic [4:0]  flg;

  always_comb begin
    if (acc_q[47]) begin
      mant = acc_q[46:24];
      g    = acc_q[23];
      s    = |acc_q[22:0];
    end else begin
      mant = acc_q[45:23];
      g    = acc_q[22];
      s    = |acc_q[21:0];
    end
    inc    = g & (s | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, inc};
    carry  = mant_r[23];
    e_pre  = {2'b00, ex} + {2'b00, ey} - 10'(BIAS) + {9'd0, acc_q[47]};
    e_fin  = e_pre + {9'd0, carry};

    res = '0;
    flg = '0;
    if (x_nan || y_nan) begin
      res = 32'h7FC0_0000;
      flg = {snan, 4'b0000};
    end else if ((x_inf && y_zero) || (y_inf && x_zero)) begin
      res = 32'h7FC0_0000;
      flg = 5'b10000;
    end else if (x_inf || y_inf) begin
      res = {sgn, 8'hFF, 23'd0};
    end else if (x_zero || y_zero) begin
      res = {sgn, 31'd0};
    end else if ($signed(e_pre) <= 10'sd0) begin
      res = {sgn, 31'd0};
      flg = 5'b00011;
    end else if ($signed(e_fin) >= 10'sd255) begin
      res = {sgn, 8'hFF, 23'd0};
      flg = 5'b00101;
    end else begin
      res = {sgn, e_fin[7:0], mant_r[22:0]};
      flg = {4'b0000, g | s};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    rslt_d   = rslt_q;
    flag_d   = flag_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          x_d      = x_i;
          y_d      = y_i;
          mcand_d  = {24'd0, (x_i[30:23] != 8'h00), x_i[22:0]};
          mplier_d = {(y_i[30:23] != 8'h00), y_i[22:0]};
          acc_d    = '0;
          cnt_d    = 4'(ITER - 1);
          busy_d   = 1'b1;
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
        if (cnt_q == 4'd0) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ROUND: begin
        rslt_d  = res;
        flag_d  = flg;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      rslt_q   <= '0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      rslt_q   <= rslt_d;
      flag_q   <= flag_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign rslt_o  = rslt_q;
  assign flag_o  = flag_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Bench for fmul_seq: directed corner cases, handshake/reset scenarios and random
// operands compared against an integer-arithmetic reference multiplier.
`timescale 1ns/1ps
module tb_fmul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic        busy, valid;
  logic [31:0] rslt;
  logic [4:0]  flag;

  int n_vec = 0;
  int n_err = 0;

  fmul_seq dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .x_i     (x),
    .y_i     (y),
    .busy_o  (busy),
    .valid_o (valid),
    .rslt_o  (rslt),
    .flag_o  (flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, rounding decided by comparing the dropped remainder to half an ulp
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f);
    int ea, eb, e, sh;
    longint unsigned p, m, rem, half;
    logic na, nb, ia, ib, za, zb, sg;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    sg = a[31] ^ b[31];
    f = 5'd0;
    if (na || nb) begin
      r = 32'h7FC00000;
      if ((na && !a[22]) || (nb && !b[22])) f = 5'b10000;
    end else if ((ia && zb) || (ib && za)) begin
      r = 32'h7FC00000;
      f = 5'b10000;
    end else if (ia || ib) begin
      r = {sg, 8'hFF, 23'd0};
    end else if (za || zb) begin
      r = {sg, 31'd0};
    end else begin
      p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e    = ea + eb - 127;
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      m    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (e <= 0) begin
        r = {sg, 31'd0};
        f = 5'b00011;
      end else begin
        if (rem > half || (rem == half && m[0])) m = m + 1;
        if (m == (64'd1 << 24)) begin
          m = m >> 1;
          e++;
        end
        if (e >= 255) begin
          r = {sg, 8'hFF, 23'd0};
          f = 5'b00101;
        end else begin
          r = {sg, 8'(e), m[22:0]};
          f = (rem != 0) ? 5'b00001 : 5'b00000;
        end
      end
    end
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req = 1'b1;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [4:0] ef);
    int c;
    start(a, b);
    chk("busy_start", 32'(busy), 32'd1);
    wait_valid(c);
    chk("latency", c, 32'd13);
    chk("rslt", rslt, er);
    chk("flag", 32'(flag), 32'(ef));
    @(posedge clk);
    #1;
    chk("valid_pulse", 32'(valid), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic do_rand(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [4:0]  ef;
    ref_mul(a, b, er, ef);
    do_op(a, b, er, ef);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] sp [8];
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h7FA00000, 32'h00000001, 32'h00800000};
    case ($urandom_range(0, 9))
      0:       return sp[$urandom_range(0, 7)];
      1:       return $urandom();
      2:       return {1'($urandom()), 8'($urandom_range(100, 150)), 20'd0, 3'($urandom())};
      default: return {1'($urandom()), 8'($urandom_range(60, 195)), 23'($urandom())};
    endcase
  endfunction

  initial begin
    int c, pulses;
    logic [31:0] er;
    logic [4:0]  ef;

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rslt", rslt, 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000);
    do_op(32'hBF800000, 32'h40400000, 32'hC0400000, 5'b00000);
    do_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001);
    do_op(32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101);
    do_op(32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011);
    do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000);
    do_op(32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'b10000);
    do_op(32'h00000001, 32'h40000000, 32'h00000000, 5'b00000);
    do_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000);
    do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000);
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 5'b00001);

    // Second request mid-operation must be ignored
    start(32'h3FC00000, 32'h40000000);
    repeat (4) @(posedge clk);
    #1;
    req = 1'b1;
    x = 32'h40A00000;
    y = 32'h40A00000;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_valid(c);
    chk("ign_latency", c, 32'd8);
    chk("ign_rslt", rslt, 32'h40400000);
    count_valid(20, pulses);
    chk("ign_no_second", pulses, 32'd0);

    // Request held high across valid: back-to-back acceptance
    @(negedge clk);
    req = 1'b1;
    x = 32'h40000000;
    y = 32'h40400000;
    @(posedge clk);
    #1;
    x = 32'h40800000;
    y = 32'hC0A00000;
    wait_valid(c);
    chk("b2b_lat1", c, 32'd13);
    chk("b2b_rslt1", rslt, 32'h40C00000);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_valid(c);
    chk("b2b_lat2", c, 32'd13);
    chk("b2b_rslt2", rslt, 32'hC1A00000);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of an operation
    start(32'h40400000, 32'h40400000);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_rslt", rslt, 32'd0);
    chk("arst_flag", 32'(flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(30, pulses);
    chk("arst_no_valid", pulses, 32'd0);
    do_op(32'h40400000, 32'h40400000, 32'h41100000, 5'b00000);

    ref_mul(32'h3FC00000, 32'h40000000, er, ef);
    chk("model_sanity", er, 32'h40400000);

    for (int i = 0; i < 160; i++) begin
      do_rand(rnd_op(), rnd_op());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fmul_seq.md
Name: fmul_seq

Overview:
- Iterative single-precision (IEEE-754 binary32) floating-point multiplier. It is the multiply counterpart to the team's iterative radix-4 divider.
- Shares the divider's operand/result/flag interface so both can sit side by side behind the same FPU issue logic.
- Computes the 24x24 significand product with a radix-4 shift-add loop (2 multiplier bits per cycle), then normalises and rounds in a final cycle.
- Fixed latency, one operation in flight.

Parameters:
- ITER, 12, radix-4 iteration count (24 significand bits / 2); fixed, not for override.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  start pulse; sampled only while busy=0.
- x  input  32  multiplicand, binary32.
- y  input  32  multiplier, binary32.
- busy  output  1  operation in progress.
- valid  output  1  one-cycle pulse: rslt/flag are new.
- rslt  output  32  product, binary32.
- flag  output  5  {NV, DZ, OF, UF, NX}; DZ is always 0.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, valid=0, rslt=0, flag=0, iteration counter=0. Reset mid-operation aborts it with no valid pulse.
- States: IDLE -> ITER -> ROUND -> IDLE.
- IDLE:
  - req=1 at edge t0: latch x and y, unpack significands (hidden bit 1 if exp!=0), clear the 48-bit accumulator, count=ITER-1, go to ITER.
  - busy=1 from t0 onward.
- ITER:
  - Each cycle, add (multiplicand x low 2 bits of remaining multiplier) into the accumulator. Use an add-shift scheme or shifted partial products; the final 48-bit product must be exact.
  - Shift the multiplier right by 2 and decrement count.
  - Edges t0+1 .. t0+12. After count reaches 0, go to ROUND.
- ROUND (edge t0+13):
  - Unbiased sum: e = ex + ey - BIAS, 10-bit signed.
  - If P[47]=1: mantissa = P[46:24], G = P[23], S = |P[22:0], e += 1. Otherwise mantissa = P[45:23], G = P[22], S = |P[21:0].
  - Round to nearest even: increment if G & (S | lsb).
  - If rounding carries out: mantissa = 0 and e += 1.
  - Sign = x[31] ^ y[31].
- Result write: at edge t0+13 update rslt and flag, set valid=1 for exactly one cycle, busy=0.
- Result hold: rslt/flag stay until the next ROUND or reset. Total latency is 14 cycles from req edge to valid-high cycle end. Special operands use the same latency.
- req while busy=1: ignored; operands are not re-latched.
- req in the same cycle valid is high: accepted (busy already 0 at that edge).
- Special cases, in priority order:
  - Either operand NaN -> 0x7FC00000. NV=1 only if any NaN is signalling (frac[22]=0).
  - inf x 0 -> 0x7FC00000, NV=1.
  - inf x finite nonzero -> signed inf, no flags.
  - Zero or denormal operand: denormals are treated as zero (flush-to-zero on input) -> signed zero, no flags.
- Overflow: final e >= 255 -> signed inf (exp=0xFF, frac=0), OF=1, NX=1.
- Underflow: e <= 0 before rounding -> signed zero, UF=1, NX=1. Subnormal results are not produced.
- Inexact: NX = G | S for normal results.

Test Plan:
- Basic product: x=0x3FC00000 (1.5), y=0x40000000 (2.0), req pulse -> busy high 13 cycles; valid on 14th cycle; rslt=0x40400000, flag=5'b00000.
- Sign and rounding:
  - x=0xBF800000, y=0x40400000 -> 0xC0400000, flag=0.
  - x=y=0x3F800001 -> 0x3F800002, flag=5'b00001 (NX).
- Overflow / underflow:
  - x=0x7F000000, y=0x40000000 -> 0x7F800000, flag=5'b00101.
  - x=0x00800000, y=0x3F000000 -> 0x00000000, flag=5'b00011.
- Specials:
  - x=0x7F800000, y=0x00000000 -> 0x7FC00000, flag=5'b10000.
  - x=0x7FA00000 (sNaN), y=0x3F800000 -> 0x7FC00000, NV=1.
  - x=0x00000001 (denormal), y=0x40000000 -> 0x00000000, flag=0.
- Handshake:
  - Second req asserted at cycle 5 of an operation -> ignored; single valid pulse with the first operation's result.
  - req held high across valid -> back-to-back operation accepted; next valid arrives 14 cycles later.
- Reset: assert reset=0 asynchronously at cycle 7 of an operation -> busy, valid, rslt, flag go to 0 immediately. After release, no valid pulse until a new req; the new req produces a correct result.
